// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU load/store
// path and a DMA/debug loader.
//
// Every access runs IDLE -> ACCESS -> RESP -> IDLE. The CPU wins ties until it
// has won MAX_CPU_STREAK consecutive contested grants. The next contested grant
// then goes to the DMA.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata    CPU request (held until cpu_ready)
//   cpu_rdata, cpu_ready     CPU response (one-cycle pulse in RESP)
//   dma_*                    DMA equivalents of the CPU ports
//   mem_en/we/addr/wdata     memory strobe and latched access fields
//   mem_rdata                memory read data, valid the cycle after mem_en
//   owner                    current grant owner (0 = CPU, 1 = DMA), debug
module dmem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  owner
);

    localparam int STREAK_WIDTH = $clog2(MAX_CPU_STREAK + 1);
    localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_CPU_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                  state_r, state_next_s;
    logic [STREAK_WIDTH-1:0] streak_r, streak_next_s;
    logic                    owner_r, owner_next_s;
    logic                    grant_s;
    logic                    we_next_s;
    logic [ADDR_WIDTH-1:0]   addr_next_s;
    logic [DATA_WIDTH-1:0]   wdata_next_s;
    logic                    mem_en_r;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;
    logic                    cpu_ready_r;
    logic                    dma_ready_r;

    // Next-state, arbitration and winner-field selection.
    always_comb begin
        state_next_s  = state_r;
        streak_next_s = streak_r;
        owner_next_s  = owner_r;
        grant_s       = 1'b0;
        we_next_s     = mem_we_r;
        addr_next_s   = mem_addr_r;
        wdata_next_s  = mem_wdata_r;

        case (state_r)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_s      = 1'b1;
                    state_next_s = ST_ACCESS;
                    if (cpu_req && dma_req) begin
                        // Contested: CPU wins until its streak reaches the cap.
                        if (streak_r < STREAK_MAX) begin
                            owner_next_s  = 1'b0;
                            streak_next_s = streak_r + STREAK_WIDTH'(1);
                        end else begin
                            owner_next_s  = 1'b1;
                            streak_next_s = {STREAK_WIDTH{1'b0}};
                        end
                    end else begin
                        owner_next_s  = dma_req;
                        streak_next_s = {STREAK_WIDTH{1'b0}};
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_next_s = ST_RESP;
            ST_RESP:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase

        // Requester fields are captured only at the grant; afterwards they are ignored.
        if (grant_s) begin
            if (owner_next_s) begin
                we_next_s    = dma_we;
                addr_next_s  = dma_addr;
                wdata_next_s = dma_wdata;
            end else begin
                we_next_s    = cpu_we;
                addr_next_s  = cpu_addr;
                wdata_next_s = cpu_wdata;
            end
        end else begin
            we_next_s    = mem_we_r;
            addr_next_s  = mem_addr_r;
            wdata_next_s = mem_wdata_r;
        end
    end

    // State, streak, latched access fields and registered strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            streak_r    <= {STREAK_WIDTH{1'b0}};
            owner_r     <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            cpu_ready_r <= 1'b0;
            dma_ready_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            streak_r    <= streak_next_s;
            owner_r     <= owner_next_s;
            mem_en_r    <= (state_next_s == ST_ACCESS);
            mem_we_r    <= we_next_s;
            mem_addr_r  <= addr_next_s;
            mem_wdata_r <= wdata_next_s;
            // owner_r is stable from ACCESS into RESP, so it selects the ready pulse.
            cpu_ready_r <= (state_next_s == ST_RESP) && (owner_r == 1'b0);
            dma_ready_r <= (state_next_s == ST_RESP) && (owner_r == 1'b1);
        end
    end

    // Read data is forwarded straight from memory during the response cycle only.
    always_comb begin
        if (cpu_ready_r && !mem_we_r) begin
            cpu_rdata = mem_rdata;
        end else begin
            cpu_rdata = {DATA_WIDTH{1'b0}};
        end
        if (dma_ready_r && !mem_we_r) begin
            dma_rdata = mem_rdata;
        end else begin
            dma_rdata = {DATA_WIDTH{1'b0}};
        end
    end

    assign cpu_ready = cpu_ready_r;
    assign dma_ready = dma_ready_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign owner     = owner_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed test-plan scenarios plus a random
// traffic phase. The bench uses a transaction-level reference model (grant
// rules, fixed latency offsets and a shadow memory) to check every cycle.
module tb_dmem_arbiter;

    localparam int MAX = 4;

    typedef struct {
        int          delay;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, dma_ready, mem_en, mem_we, owner;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_CPU_STREAK(MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    // Memory storage: one-cycle read latency, write committed on the mem_en edge.
    logic [31:0] store [64];
    initial begin
        for (int i = 0; i < 64; i++) store[i] <= 32'h0;
        mem_rdata <= 32'h0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) store[mem_addr[7:2]] <= mem_wdata;
                else        mem_rdata <= store[mem_addr[7:2]];
            end
        end
    end

    // Reference model state
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          since;          // cycles since the last grant edge (0 = none pending)
    int          streak;
    int          grant_cnt;
    int          reset_at_grant;
    logic        g_own, g_we;
    logic [31:0] g_addr, g_wdata, g_rdata;
    logic [31:0] shadow [64];
    op_t         cq[$], dq[$];
    logic        c_act, d_act;
    logic        wiggle;
    int          dut_log[$], dut_cyc[$];
    logic [31:0] last_cpu_rdata, last_dma_rdata, last_resp_addr;
    int          cpu_ready_cnt, dma_ready_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'h0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_cpu_ready"}, 32'(cpu_ready), 32'h0);
        chk({tag, "_dma_ready"}, 32'(dma_ready), 32'h0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
        chk({tag, "_dma_rdata"}, dma_rdata, 32'h0);
        chk({tag, "_owner"}, 32'(owner), 32'h0);
    endtask

    task automatic clear_model();
        since = 0; streak = 0; g_own = 1'b0; g_we = 1'b0;
        g_addr = 32'h0; g_wdata = 32'h0; g_rdata = 32'h0;
        cq.delete(); dq.delete(); c_act = 1'b0; d_act = 1'b0;
        cpu_req = 1'b0; dma_req = 1'b0; reset_at_grant = -1;
    endtask

    task automatic drive_cpu();
        op_t op;
        if (!c_act) begin
            cpu_req = 1'b0;
            if (cq.size() > 0) begin
                op = cq.pop_front();
                if (op.delay > 0) begin
                    op.delay--;
                    cq.push_front(op);
                end else begin
                    c_act = 1'b1; cpu_req = 1'b1;
                    cpu_we = op.we; cpu_addr = op.addr; cpu_wdata = op.wdata;
                end
            end
        end
    endtask

    task automatic drive_dma();
        op_t op;
        if (!d_act) begin
            dma_req = 1'b0;
            if (dq.size() > 0) begin
                op = dq.pop_front();
                if (op.delay > 0) begin
                    op.delay--;
                    dq.push_front(op);
                end else begin
                    d_act = 1'b1; dma_req = 1'b1;
                    dma_we = op.we; dma_addr = op.addr; dma_wdata = op.wdata;
                end
            end
        end
    endtask

    // One clock: check outputs at the negedge, drive requesters, advance the model.
    task automatic step();
        logic exp_cr, exp_dr;
        @(negedge clk);
        cyc++;
        exp_cr = (since == 2) && (g_own == 1'b0);
        exp_dr = (since == 2) && (g_own == 1'b1);
        chk("mem_en", 32'(mem_en), 32'(since == 1));
        if (since == 1) begin
            chk("mem_we", 32'(mem_we), 32'(g_we));
            chk("mem_addr", mem_addr, g_addr);
            chk("mem_wdata", mem_wdata, g_wdata);
        end
        chk("cpu_ready", 32'(cpu_ready), 32'(exp_cr));
        chk("dma_ready", 32'(dma_ready), 32'(exp_dr));
        chk("cpu_rdata", cpu_rdata, (exp_cr && !g_we) ? g_rdata : 32'h0);
        chk("dma_rdata", dma_rdata, (exp_dr && !g_we) ? g_rdata : 32'h0);
        chk("owner", 32'(owner), 32'(g_own));
        if (mem_en) begin dut_log.push_back(int'(owner)); dut_cyc.push_back(cyc); end
        if (cpu_ready) begin last_cpu_rdata = cpu_rdata; cpu_ready_cnt++; end
        if (dma_ready) begin last_dma_rdata = dma_rdata; dma_ready_cnt++; end
        if (wiggle && since == 2) last_resp_addr = mem_addr;

        if (since == 1 && grant_cnt == reset_at_grant) begin
            reset_n = 1'b0;
            #1;
            chk_all_zero("midreset");
            clear_model();
            #1;
            reset_n = 1'b1;
            return;
        end

        if (since == 2) begin
            if (g_own) d_act = 1'b0;
            else       c_act = 1'b0;
        end
        drive_cpu();
        drive_dma();
        if (wiggle && since == 1 && !g_own) cpu_addr = 32'h20;

        // Model of the coming rising edge.
        if (since == 1) begin
            if (g_we) shadow[g_addr[7:2]] = g_wdata;
            else      g_rdata = shadow[g_addr[7:2]];
            since = 2;
        end else if (since == 2) begin
            since = 3;
        end else if (cpu_req || dma_req) begin
            if (cpu_req && (!dma_req || streak < MAX)) begin
                g_own = 1'b0;
                streak = dma_req ? streak + 1 : 0;
                g_we = cpu_we; g_addr = cpu_addr; g_wdata = cpu_wdata;
            end else begin
                g_own = 1'b1;
                streak = 0;
                g_we = dma_we; g_addr = dma_addr; g_wdata = dma_wdata;
            end
            grant_cnt++;
            since = 1;
        end else begin
            since = 0;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((cq.size() > 0 || dq.size() > 0 || c_act || d_act || since == 1 || since == 2)
               && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < budget), 32'h1);
    endtask

    task automatic new_test();
        dut_log.delete(); dut_cyc.delete();
        last_cpu_rdata = 32'h0; last_dma_rdata = 32'h0;
        cpu_ready_cnt = 0; dma_ready_cnt = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
        wiggle = 1'b0; grant_cnt = 0; last_resp_addr = 32'h0;
        clear_model();
        for (int i = 0; i < 64; i++) shadow[i] = 32'h0;
        new_test();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // CPU write then read of address 0, DMA idle.
        new_test();
        cq.push_back('{0, 1'b1, 32'h0, 32'hFEFEFEFE});
        cq.push_back('{0, 1'b0, 32'h0, 32'h0});
        drain("t1", 100);
        chk("t1_rdata", last_cpu_rdata, 32'hFEFEFEFE);
        chk("t1_accesses", 32'(dut_log.size()), 32'd2);
        chk("t1_dma_ready", 32'(dma_ready_cnt), 32'd0);

        // DMA fills 0..60, then CPU reads 60.
        new_test();
        for (int i = 0; i < 16; i++) dq.push_back('{0, 1'b1, 32'(i * 4), 32'hFEFEFEFE});
        drain("t2a", 200);
        chk("t2_count", 32'(dut_cyc.size()), 32'd16);
        for (int i = 0; i + 1 < dut_cyc.size(); i++)
            chk("t2_spacing", 32'(dut_cyc[i+1] - dut_cyc[i]), 32'd3);
        cq.push_back('{0, 1'b0, 32'd60, 32'h0});
        drain("t2b", 100);
        chk("t2_rdata", last_cpu_rdata, 32'hFEFEFEFE);

        // Simultaneous single requests: CPU first, DMA three cycles later.
        new_test();
        cq.push_back('{0, 1'b1, 32'h40, 32'hA5A5A5A5});
        dq.push_back('{0, 1'b0, 32'h40, 32'h0});
        drain("t3", 100);
        chk("t3_count", 32'(dut_log.size()), 32'd2);
        if (dut_log.size() == 2) begin
            chk("t3_first", 32'(dut_log[0]), 32'd0);
            chk("t3_second", 32'(dut_log[1]), 32'd1);
            chk("t3_gap", 32'(dut_cyc[1] - dut_cyc[0]), 32'd3);
        end
        chk("t3_dma_rdata", last_dma_rdata, 32'hA5A5A5A5);

        // Both held continuously: C,C,C,C,D repeating.
        new_test();
        for (int i = 0; i < 10; i++) begin
            cq.push_back('{0, 1'b1, 32'(i * 4), $urandom});
            dq.push_back('{0, 1'b1, 32'(64 + i * 4), $urandom});
        end
        drain("t4", 300);
        for (int i = 0; i < 10 && i < dut_log.size(); i++)
            chk("t4_grant", 32'(dut_log[i]), 32'(i % 5 == 4));

        // Reset during ACCESS of a CPU write: write dropped, no ready.
        new_test();
        cq.push_back('{0, 1'b1, 32'h8, 32'h11111111});
        drain("t5a", 100);
        new_test();
        grant_cnt = 0; reset_at_grant = 1;
        cq.push_back('{0, 1'b1, 32'h8, 32'h22222222});
        drain("t5b", 100);
        chk("t5_no_ready", 32'(cpu_ready_cnt), 32'd0);
        cq.push_back('{0, 1'b0, 32'h8, 32'h0});
        drain("t5c", 100);
        chk("t5_rdata", last_cpu_rdata, 32'h11111111);

        // Reset in the middle of a CPU streak: streak restarts from 0.
        new_test();
        for (int i = 0; i < 10; i++) begin
            cq.push_back('{0, 1'b0, 32'(i * 4), 32'h0});
            dq.push_back('{0, 1'b0, 32'(i * 4), 32'h0});
        end
        grant_cnt = 0; reset_at_grant = 3;
        drain("t5d", 200);
        new_test();
        for (int i = 0; i < 5; i++) begin
            cq.push_back('{0, 1'b0, 32'(i * 4), 32'h0});
            dq.push_back('{0, 1'b0, 32'(i * 4), 32'h0});
        end
        drain("t5e", 200);
        for (int i = 0; i < 5 && i < dut_log.size(); i++)
            chk("t5_streak_grant", 32'(dut_log[i]), 32'(i == 4));

        // Requester address changes after the grant.
        new_test();
        wiggle = 1'b1;
        cq.push_back('{0, 1'b0, 32'h10, 32'h0});
        drain("t6", 100);
        wiggle = 1'b0;
        chk("t6_resp_addr", last_resp_addr, 32'h10);

        // Random traffic against the reference model.
        new_test();
        for (int i = 0; i < 40; i++) begin
            cq.push_back('{int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           32'($urandom_range(0, 63) * 4), $urandom});
            dq.push_back('{int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           32'($urandom_range(0, 63) * 4), $urandom});
        end
        drain("t7", 3000);
        chk("t7_count", 32'(dut_log.size()), 32'd80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
